ann_coef_loader: RTL and testbench

- Supplier side of the ANN's image/weight interface.
- Fetches the input image and per-layer coefficient banks from a word-addressed read port into local buffers, which drive the ANN's image and weights arrays.
- Pulses image_weights_loaded once the ANN's data is complete.
- Services the ANN's request_coef/coef_select reload requests between layers.

---
 rtl/ann_pkg.sv | 20 ++
 rtl/ann_coef_loader_if.sv | 25 ++
 rtl/ann_coef_loader_mem_word_reader.sv | 71 +++++++
 rtl/ann_coef_loader.sv | 125 ++++++++++++
 tb/tb_ann_coef_loader.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ann_pkg.sv
// Shared types and helpers for the ANN coefficient loader.
package ann_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoadImg,
    StLoadW,
    StDone
  } loader_state_t;

  // First address of a coefficient bank; banks are packed back to back after wbase.
  function automatic int unsigned bank_addr(input logic [1:0]  bank,
                                            input int unsigned wbase,
                                            input int unsigned bank_words);
    return wbase + 32'(bank) * bank_words;
  endfunction

endpackage

// File: rtl/ann_coef_loader_if.sv
// Word-addressed read port: one outstanding request, data valid same cycle or later.
interface ann_coef_loader_if #(
  parameter int unsigned ADDR_W = 16
);

  logic                      mem_req;
  logic [ADDR_W-1:0]         mem_addr;
  logic [ann_pkg::WORD_W-1:0] mem_rdata;
  logic                      mem_rvalid;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_rvalid
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_rvalid
  );

endinterface

// File: rtl/ann_coef_loader_mem_word_reader.sv
// Sequential word reader: issues reads from a base address, one outstanding at a time,
// and reports each accepted word with its index. A new command may be issued in the
// cycle the last word is accepted so back-to-back runs have no bubble.
module mem_word_reader import ann_pkg::*; #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_start_i,
  input  logic [ADDR_W-1:0]   cmd_base_i,
  input  logic [CNT_W-1:0]    cmd_last_i,
  ann_coef_loader_if.master   mem,
  output logic                wr_en_o,
  output logic [CNT_W-1:0]    wr_index_o,
  output logic [WORD_W-1:0]   wr_data_o,
  output logic                last_o
);

  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  last_idx_q, last_idx_d;
  logic              accept;

  // rvalid only counts while a request is outstanding
  assign accept       = req_q & mem.mem_rvalid;
  assign wr_en_o      = accept;
  assign wr_index_o   = cnt_q;
  assign wr_data_o    = mem.mem_rdata;
  assign last_o       = accept & (cnt_q == last_idx_q);
  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

  // Next request/address/counter
  always_comb begin
    req_d      = req_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    if (cmd_start_i) begin
      req_d      = 1'b1;
      addr_d     = cmd_base_i;
      cnt_d      = '0;
      last_idx_d = cmd_last_i;
    end else if (accept) begin
      addr_d = addr_q + 1'b1;
      if (cnt_q == last_idx_q) begin
        req_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Reader state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      last_idx_q <= '0;
    end else begin
      req_q      <= req_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
    end
  end

endmodule

// File: rtl/ann_coef_loader.sv
// Loads the ANN input image and a coefficient bank from memory into local buffers,
// pulses image_weights_loaded on completion, and services between-layer bank reloads.
module ann_coef_loader import ann_pkg::*; #(
  parameter int unsigned FIRST_LAYER = 16,
  parameter int unsigned IMAGE_SIZE  = 64,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WBASE       = 64
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start_load,
  input  logic                                            request_coef,
  input  logic                                            coef_select,
  ann_coef_loader_if.master                               mem,
  output logic [IMAGE_SIZE-1:0][WORD_W-1:0]               image,
  output logic [FIRST_LAYER-1:0][IMAGE_SIZE-1:0][WORD_W-1:0] weights,
  output logic                                            image_weights_loaded,
  output logic                                            busy
);

  localparam int unsigned BANK_WORDS = FIRST_LAYER * IMAGE_SIZE;
  localparam int unsigned CNT_W      = $clog2(BANK_WORDS);
  localparam int unsigned IMG_W      = $clog2(IMAGE_SIZE);

  loader_state_t state_q, state_d;

  // Weights kept flat: slot k is node k/IMAGE_SIZE, input k%IMAGE_SIZE
  logic [IMAGE_SIZE-1:0][WORD_W-1:0] image_q, image_d;
  logic [BANK_WORDS-1:0][WORD_W-1:0] weights_q, weights_d;

  logic              cmd_start;
  logic [ADDR_W-1:0] cmd_base;
  logic [CNT_W-1:0]  cmd_last;
  logic              wr_en;
  logic [CNT_W-1:0]  wr_index;
  logic [WORD_W-1:0] wr_data;
  logic              last;

  mem_word_reader #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_reader (
    .clk         (clk),
    .rst         (rst),
    .cmd_start_i (cmd_start),
    .cmd_base_i  (cmd_base),
    .cmd_last_i  (cmd_last),
    .mem         (mem),
    .wr_en_o     (wr_en),
    .wr_index_o  (wr_index),
    .wr_data_o   (wr_data),
    .last_o      (last)
  );

  assign image                = image_q;
  assign weights              = weights_q;
  assign image_weights_loaded = (state_q == StDone);
  assign busy                 = (state_q != StIdle);

  // Next-state, reader commands and buffer writes
  always_comb begin
    state_d   = state_q;
    image_d   = image_q;
    weights_d = weights_q;
    cmd_start = 1'b0;
    cmd_base  = '0;
    cmd_last  = '0;
    unique case (state_q)
      StIdle: begin
        // start_load has priority; a held request_coef is picked up on the next return here
        if (start_load) begin
          cmd_start = 1'b1;
          cmd_base  = '0;
          cmd_last  = CNT_W'(IMAGE_SIZE - 1);
          state_d   = StLoadImg;
        end else if (request_coef) begin
          cmd_start = 1'b1;
          cmd_base  = ADDR_W'(bank_addr(coef_select ? 2'd2 : 2'd1, WBASE, BANK_WORDS));
          cmd_last  = CNT_W'(BANK_WORDS - 1);
          state_d   = StLoadW;
        end
      end
      StLoadImg: begin
        if (wr_en) begin
          image_d[wr_index[IMG_W-1:0]] = wr_data;
        end
        if (last) begin
          // chain straight into bank 0 so mem_req stays high
          cmd_start = 1'b1;
          cmd_base  = ADDR_W'(bank_addr(2'd0, WBASE, BANK_WORDS));
          cmd_last  = CNT_W'(BANK_WORDS - 1);
          state_d   = StLoadW;
        end
      end
      StLoadW: begin
        if (wr_en) begin
          weights_d[wr_index] = wr_data;
        end
        if (last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and buffer registers; reset clears buffers too
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      image_q   <= '0;
      weights_q <= '0;
    end else begin
      state_q   <= state_d;
      image_q   <= image_d;
      weights_q <= weights_d;
    end
  end

endmodule

// File: tb/tb_ann_coef_loader.sv
// Self-checking bench for ann_coef_loader: latency-configurable responder returning
// addr+salt, reference buffers and address list built from the load rules.
module tb_ann_coef_loader;
  import ann_pkg::*;

  localparam int unsigned FL = 16;
  localparam int unsigned IS = 64;
  localparam int unsigned AW = 16;
  localparam int unsigned WB = 64;
  localparam int unsigned BW = FL * IS;

  logic clk = 1'b0;
  logic rst;
  logic start_load;
  logic request_coef;
  logic coef_select;
  logic [IS-1:0][15:0]         image;
  logic [FL-1:0][IS-1:0][15:0] weights;
  logic iwl;
  logic busy;

  ann_coef_loader_if #(.ADDR_W(AW)) mem_if ();

  ann_coef_loader #(
    .FIRST_LAYER (FL),
    .IMAGE_SIZE  (IS),
    .ADDR_W      (AW),
    .WBASE       (WB)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start_load           (start_load),
    .request_coef         (request_coef),
    .coef_select          (coef_select),
    .mem                  (mem_if),
    .image                (image),
    .weights              (weights),
    .image_weights_loaded (iwl),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  // Responder: data = addr + salt, valid after lat waiting cycles
  int          lat = 0;
  logic [15:0] salt = 16'd1;
  logic        stray = 1'b0;
  int          wait_cnt = 0;

  assign mem_if.mem_rdata  = mem_if.mem_addr + salt;
  assign mem_if.mem_rvalid = stray | (mem_if.mem_req && (wait_cnt >= lat));

  always @(posedge clk) begin
    if (!mem_if.mem_req || mem_if.mem_rvalid) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Monitor: accepted addresses, pulses, address stability while waiting
  logic [15:0] acc_q[$];
  int          pulses = 0;
  int          stab_err = 0;
  bit          held = 1'b0;
  logic [15:0] held_addr = '0;

  always @(posedge clk) begin
    if (rst) begin
      held <= 1'b0;
    end else begin
      if (iwl) pulses <= pulses + 1;
      if (held && (!mem_if.mem_req || mem_if.mem_addr !== held_addr)) stab_err <= stab_err + 1;
      held      <= mem_if.mem_req && !mem_if.mem_rvalid;
      held_addr <= mem_if.mem_addr;
      if (mem_if.mem_req && mem_if.mem_rvalid) acc_q.push_back(mem_if.mem_addr);
    end
  end

  // Reference model
  logic [15:0] img_m [IS];
  logic [15:0] w_m   [BW];
  logic [15:0] exp_q[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < IS; k++) img_m[k] = '0;
    for (int k = 0; k < BW; k++) w_m[k] = '0;
  endtask

  task automatic model_load(input int bank, input bit with_img);
    int base;
    if (with_img) begin
      for (int k = 0; k < IS; k++) begin
        img_m[k] = 16'(k) + salt;
        exp_q.push_back(16'(k));
      end
    end
    base = WB + bank * BW;
    for (int k = 0; k < BW; k++) begin
      w_m[k] = 16'(base + k) + salt;
      exp_q.push_back(16'(base + k));
    end
  endtask

  task automatic check_bufs(input string tag);
    int bad = 0;
    for (int k = 0; k < IS; k++) if (image[k] !== img_m[k]) bad++;
    for (int k = 0; k < BW; k++) if (weights[k / IS][k % IS] !== w_m[k]) bad++;
    check({tag, "_bufs"}, bad, 0);
  endtask

  task automatic check_addrs(input string tag);
    int bad = 0;
    check({tag, "_nreads"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= acc_q.size() || acc_q[i] !== exp_q[i]) bad++;
    check({tag, "_addrs"}, bad, 0);
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
  endtask

  task automatic wait_pulse(input string tag, input int maxc, output int n);
    int busy_bad = 0;
    n = 0;
    while (!iwl && n < maxc) begin
      tick();
      n++;
      if (!busy) busy_bad++;
    end
    check({tag, "_pulse_seen"}, iwl, 1);
    check({tag, "_busy_during"}, busy_bad, 0);
  endtask

  initial begin
    int n;
    int k;
    int p0;
    int sz0;

    rst = 1'b1;
    start_load = 1'b0;
    request_coef = 1'b0;
    coef_select = 1'b0;
    model_clear();
    repeat (3) tick();

    // Reset state
    check("rst_req", mem_if.mem_req, 0);
    check("rst_addr", mem_if.mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_pulse", iwl, 0);
    check_bufs("rst");
    rst = 1'b0;
    tick();

    // Full load, zero-latency responder, data = addr+1
    lat = 0;
    salt = 16'd1;
    model_load(0, 1);
    p0 = pulses;
    pulse_start();
    wait_pulse("t1", 5000, n);
    check("t1_latency", n, 1088);
    tick();
    check("t1_busy_after", busy, 0);
    check("t1_req_after", mem_if.mem_req, 0);
    check("t1_npulses", pulses - p0, 1);
    check_bufs("t1");
    check_addrs("t1");

    // Full load, 3-cycle latency, random data
    lat = 3;
    salt = 16'($urandom);
    model_load(0, 1);
    p0 = pulses;
    pulse_start();
    wait_pulse("t2", 20000, n);
    check("t2_latency", n, 1088 * 4);
    tick();
    check("t2_npulses", pulses - p0, 1);
    check("t2_stable", stab_err, 0);
    check_bufs("t2");
    check_addrs("t2");

    // Bank-2 reload with coef_select toggled mid-load
    lat = 0;
    salt = 16'($urandom);
    model_load(2, 0);
    p0 = pulses;
    coef_select = 1'b1;
    request_coef = 1'b1;
    tick();
    request_coef = 1'b0;
    k = $urandom_range(5, 500);
    repeat (k) tick();
    coef_select = 1'b0;
    wait_pulse("t3", 5000, n);
    check("t3_latency", k + n, 1024);
    tick();
    check("t3_npulses", pulses - p0, 1);
    check_bufs("t3");
    check_addrs("t3");

    // Reset at word 500 of the weight load
    lat = 0;
    salt = 16'($urandom);
    p0 = pulses;
    sz0 = acc_q.size();
    pulse_start();
    n = 0;
    while (acc_q.size() < sz0 + 564 && n < 2000) begin
      tick();
      n++;
    end
    check("t4_reached", acc_q.size(), sz0 + 564);
    for (int j = 0; j < IS; j++) exp_q.push_back(16'(j));
    for (int j = 0; j < 500; j++) exp_q.push_back(16'(WB + j));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check("t4_req", mem_if.mem_req, 0);
    check("t4_addr", mem_if.mem_addr, 0);
    check("t4_busy", busy, 0);
    check_bufs("t4_cleared");
    repeat (20) tick();
    check("t4_no_pulse", pulses - p0, 0);
    check("t4_idle", busy, 0);
    lat = $urandom_range(0, 2);
    salt = 16'($urandom);
    model_load(0, 1);
    pulse_start();
    wait_pulse("t4b", 10000, n);
    check("t4b_latency", n, 1088 * (lat + 1));
    tick();
    check("t4b_npulses", pulses - p0, 1);
    check_bufs("t4b");
    check_addrs("t4b");

    // start_load and request_coef together, request held: load then bank-1 reload
    lat = 0;
    salt = 16'($urandom);
    model_load(0, 1);
    model_load(1, 0);
    p0 = pulses;
    coef_select = 1'b0;
    start_load = 1'b1;
    request_coef = 1'b1;
    tick();
    start_load = 1'b0;
    wait_pulse("t5a", 5000, n);
    check("t5a_latency", n, 1088);
    tick();
    check("t5_idle_gap", busy, 0);
    tick();
    check("t5_reload_start", busy, 1);
    request_coef = 1'b0;
    wait_pulse("t5b", 5000, n);
    check("t5b_latency", n, 1024);
    repeat (20) tick();
    check("t5_npulses", pulses - p0, 2);
    check("t5_idle", busy, 0);
    check_bufs("t5");
    check_addrs("t5");

    // Stray rvalid while idle
    p0 = pulses;
    salt = 16'($urandom);
    stray = 1'b1;
    repeat (10) tick();
    stray = 1'b0;
    tick();
    check("t6_busy", busy, 0);
    check("t6_req", mem_if.mem_req, 0);
    check("t6_npulses", pulses - p0, 0);
    check_bufs("t6");
    check_addrs("t6");
    check("final_stable", stab_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
